// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router: header decode, byte steering into the output FIFOs, backpressure and parity.
// Optional macro PARITY_CHECK_EN compiles in the received-vs-computed parity compare.
module router_ingress_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic [7:0] dout,
    output logic       lfd_state,
    output logic       parity_done,
    output logic       err
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_EMPTY = 2'd1;
    localparam logic [1:0] XFER       = 2'd2;
    localparam logic [1:0] DROP       = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] holdData_q, holdData_d;
    logic       holdValid_q, holdValid_d;
    logic       holdHdr_q, holdHdr_d;
    logic [6:0] rem_q, rem_d;
    logic       dropErr_q, dropErr_d;
`ifdef PARITY_CHECK_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] rxPar_q, rxPar_d;
`endif

    logic       selFull, selEmpty, selAbort, hdrEmpty;
    logic       aborting, writeWindow, doWrite, accept, parityWrite, parityBad, dropLast;
    logic [1:0] hdrAddr;
    logic [6:0] hdrRem;

    function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
        case (a)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    // The header write is allowed in the very cycle the selected FIFO reports empty.
    always_comb begin
        hdrAddr     = data_in[1:0];
        hdrRem      = {1'b0, data_in[7:2]} + 7'd1;
        hdrEmpty    = pick(fifo_empty, hdrAddr);
        selFull     = pick(fifo_full, addr_q);
        selEmpty    = pick(fifo_empty, addr_q);
        selAbort    = pick(soft_reset, addr_q);
        aborting    = ((state_q == WAIT_EMPTY) || (state_q == XFER)) && selAbort;
        writeWindow = (state_q == XFER) || ((state_q == WAIT_EMPTY) && selEmpty);
        doWrite     = holdValid_q && !selFull && writeWindow && !aborting;
        busy        = (state_q == WAIT_EMPTY) || (holdValid_q && selFull) ||
                      ((state_q == XFER) && (rem_q == 7'd0) && holdValid_q);
        accept      = pkt_valid && !busy;
        parityWrite = doWrite && (state_q == XFER) && (rem_q == 7'd0);
        dropLast    = (state_q == DROP) && accept && (rem_q == 7'd1);
`ifdef PARITY_CHECK_EN
        parityBad   = (rxPar_q != acc_q);
`else
        parityBad   = 1'b0;
`endif
        write_enb   = doWrite ? (3'b001 << addr_q) : 3'b000;
        dout        = holdData_q;
        lfd_state   = holdValid_q && holdHdr_q;
        parity_done = parityWrite;
        err         = (dropLast && dropErr_q) || (parityWrite && parityBad);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        holdData_d  = holdData_q;
        holdValid_d = holdValid_q;
        holdHdr_d   = holdHdr_q;
        rem_d       = rem_q;
        dropErr_d   = dropErr_q;
`ifdef PARITY_CHECK_EN
        acc_d       = acc_q;
        rxPar_d     = rxPar_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d = hdrRem;
                    if (hdrAddr == 2'd3) begin
                        dropErr_d = 1'b1;
                        state_d   = DROP;
                    end else begin
                        addr_d      = hdrAddr;
                        holdData_d  = data_in;
                        holdValid_d = 1'b1;
                        holdHdr_d   = 1'b1;
`ifdef PARITY_CHECK_EN
                        acc_d       = data_in;
`endif
                        state_d     = hdrEmpty ? XFER : WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                if (doWrite) holdValid_d = 1'b0;
                if (selEmpty) state_d = XFER;
            end
            XFER: begin
                if (doWrite) holdValid_d = 1'b0;
                if (accept) begin
                    holdData_d  = data_in;
                    holdValid_d = 1'b1;
                    holdHdr_d   = 1'b0;
                    rem_d       = rem_q - 7'd1;
`ifdef PARITY_CHECK_EN
                    if (rem_q == 7'd1) rxPar_d = data_in;
                    else               acc_d   = acc_q ^ data_in;
`endif
                end
                if (parityWrite) state_d = IDLE;
            end
            DROP: begin
                if (rem_q == 7'd0) begin
                    state_d = IDLE;
                end else if (accept) begin
                    rem_d = rem_q - 7'd1;
                    if (rem_q == 7'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // An aborted packet drains silently: whatever is left is consumed without writes or err.
        if (aborting) begin
            holdValid_d = 1'b0;
            dropErr_d   = 1'b0;
            state_d     = DROP;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= 2'd0;
            holdData_q  <= 8'h00;
            holdValid_q <= 1'b0;
            holdHdr_q   <= 1'b0;
            rem_q       <= 7'd0;
            dropErr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            acc_q       <= 8'h00;
            rxPar_q     <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            holdData_q  <= holdData_d;
            holdValid_q <= holdValid_d;
            holdHdr_q   <= holdHdr_d;
            rem_q       <= rem_d;
            dropErr_q   <= dropErr_d;
`ifdef PARITY_CHECK_EN
            acc_q       <= acc_d;
            rxPar_q     <= rxPar_d;
`endif
        end
    end

endmodule
